// File: rtl/snoop_responder.sv
// Snoop responder: accepts one coherent snoop at a time on the AC channel,
// looks the line up in the local cache tags, optionally updates the line
// state, answers on CR and, when data must be returned, streams the whole
// line on CD by reading it beat by beat from the line data array.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   ac_valid_i/ac_ready_o         snoop request handshake
//   ac_addr_i/ac_snoop_i/ac_prot_i  snoop payload (prot is captured only)
//   lu_req_o/lu_addr_o            tag lookup request, held until granted
//   lu_gnt_i/lu_hit_i/lu_dirty_i/lu_shared_i  lookup result, valid with grant
//   upd_valid_o/upd_inval_o/upd_clean_o/upd_shared_o  one-cycle state update
//   rd_req_o/rd_beat_o/rd_data_i  line data read, data one cycle after req
//   cr_valid_o/cr_ready_i/cr_resp_o  snoop response
//   cd_valid_o/cd_ready_i/cd_data_o/cd_last_o  snoop data beats

package snoop_responder_pkg;

  typedef enum logic [3:0] {
    SNP_READ_ONCE             = 4'b0000,
    SNP_READ_SHARED           = 4'b0001,
    SNP_READ_CLEAN            = 4'b0010,
    SNP_READ_NOT_SHARED_DIRTY = 4'b0011,
    SNP_READ_UNIQUE           = 4'b0111,
    SNP_CLEAN_SHARED          = 4'b1000,
    SNP_CLEAN_INVALID         = 4'b1001,
    SNP_MAKE_INVALID          = 4'b1101,
    SNP_DVM_COMPLETE          = 4'b1110,
    SNP_DVM_MESSAGE           = 4'b1111
  } acsnoop_t;

  typedef logic [2:0] acprot_t;

  typedef struct packed {
    logic was_unique;     // [4]
    logic is_shared;      // [3]
    logic pass_dirty;     // [2]
    logic error;          // [1]
    logic data_transfer;  // [0]
  } resp_t;

endpackage

module snoop_responder
  import snoop_responder_pkg::*;
#(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineBeats = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ac_valid_i,
  output logic                         ac_ready_o,
  input  logic [AddrWidth-1:0]         ac_addr_i,
  input  acsnoop_t                     ac_snoop_i,
  input  acprot_t                      ac_prot_i,
  output logic                         lu_req_o,
  output logic [AddrWidth-1:0]         lu_addr_o,
  input  logic                         lu_gnt_i,
  input  logic                         lu_hit_i,
  input  logic                         lu_dirty_i,
  input  logic                         lu_shared_i,
  output logic                         upd_valid_o,
  output logic                         upd_inval_o,
  output logic                         upd_clean_o,
  output logic                         upd_shared_o,
  output logic                         rd_req_o,
  output logic [$clog2(LineBeats)-1:0] rd_beat_o,
  input  logic [DataWidth-1:0]         rd_data_i,
  output logic                         cr_valid_o,
  input  logic                         cr_ready_i,
  output resp_t                        cr_resp_o,
  output logic                         cd_valid_o,
  input  logic                         cd_ready_i,
  output logic [DataWidth-1:0]         cd_data_o,
  output logic                         cd_last_o
);

  localparam int BeatW = $clog2(LineBeats);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP,
    S_DATA_RD,
    S_DATA_TX
  } state_t;

  // Everything the snoop type decides once the lookup result is known.
  typedef struct packed {
    resp_t resp;
    logic  upd;
    logic  inval;
    logic  clean;
    logic  shared;
  } action_t;

  state_t               state_q, state_d;
  logic [BeatW-1:0]     beat_q;
  logic [AddrWidth-1:0] addr_q;
  acsnoop_t             snoop_q;
  acprot_t              prot_q;
  resp_t                resp_q;
  logic [DataWidth-1:0] data_q;
  logic                 data_held_q;
  action_t              act;
  logic                 last_beat;

  // Protection attributes are recorded with the snoop but play no part in
  // the response; this reduction only keeps the captured copy referenced.
  logic unused_prot;
  assign unused_prot = ^prot_q;

  function automatic logic needs_lookup(acsnoop_t snoop);
    case (snoop)
      SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN,
      SNP_READ_NOT_SHARED_DIRTY, SNP_READ_UNIQUE, SNP_CLEAN_SHARED,
      SNP_CLEAN_INVALID, SNP_MAKE_INVALID: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // Response for snoops that never touch the tags: DVM traffic answers
  // "nothing here", unknown encodings answer with the error bit.
  function automatic resp_t bypass_resp(acsnoop_t snoop);
    resp_t r;
    r = '0;
    if (!needs_lookup(snoop) &&
        snoop != SNP_DVM_COMPLETE && snoop != SNP_DVM_MESSAGE) begin
      r.error = 1'b1;
    end
    return r;
  endfunction

  function automatic action_t lookup_action(acsnoop_t snoop, logic hit,
                                            logic dirty, logic shared);
    action_t a;
    a = '0;
    if (hit) begin
      a.resp.was_unique = ~shared;
      case (snoop)
        SNP_READ_ONCE: begin
          a.resp.data_transfer = 1'b1;
          a.resp.is_shared     = 1'b1;
        end
        SNP_READ_SHARED, SNP_READ_NOT_SHARED_DIRTY: begin
          a.resp.data_transfer = 1'b1;
          a.resp.is_shared     = 1'b1;
          a.resp.pass_dirty    = dirty;
          a.upd                = 1'b1;
          a.shared             = 1'b1;
          a.clean              = dirty;
        end
        SNP_READ_CLEAN: begin
          a.resp.data_transfer = 1'b1;
          a.resp.is_shared     = 1'b1;
          a.upd                = 1'b1;
          a.shared             = 1'b1;
        end
        SNP_READ_UNIQUE: begin
          a.resp.data_transfer = 1'b1;
          a.resp.pass_dirty    = dirty;
          a.upd                = 1'b1;
          a.inval              = 1'b1;
        end
        SNP_CLEAN_SHARED: begin
          a.resp.data_transfer = dirty;
          a.resp.pass_dirty    = dirty;
          a.resp.is_shared     = 1'b1;
          a.upd                = 1'b1;
          a.clean              = dirty;
        end
        SNP_CLEAN_INVALID: begin
          a.resp.data_transfer = dirty;
          a.resp.pass_dirty    = dirty;
          a.upd                = 1'b1;
          a.inval              = 1'b1;
        end
        SNP_MAKE_INVALID: begin
          a.upd   = 1'b1;
          a.inval = 1'b1;
        end
        default: a = '0;
      endcase
    end
    return a;
  endfunction

  assign act       = lookup_action(snoop_q, lu_hit_i, lu_dirty_i, lu_shared_i);
  assign last_beat = (beat_q == BeatW'(LineBeats - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      addr_q      <= '0;
      snoop_q     <= SNP_READ_ONCE;
      prot_q      <= '0;
      resp_q      <= '0;
      data_q      <= '0;
      data_held_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (ac_valid_i) begin
            addr_q  <= ac_addr_i;
            snoop_q <= ac_snoop_i;
            prot_q  <= ac_prot_i;
            resp_q  <= bypass_resp(ac_snoop_i);
          end
        end
        S_LOOKUP: begin
          if (lu_gnt_i) resp_q <= act.resp;
        end
        S_DATA_RD: begin
          data_held_q <= 1'b0;
        end
        S_DATA_TX: begin
          // Read data is only guaranteed in the first DATA_TX cycle; keep a
          // copy so the beat stays stable however long CD is stalled.
          if (!data_held_q) begin
            data_q      <= rd_data_i;
            data_held_q <= 1'b1;
          end
          // Power-of-two line length: the increment wraps to 0 by itself.
          if (cd_ready_i) beat_q <= beat_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output and next-state term gets a default before the case,
  // so no path through the block can leave a value unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    ac_ready_o   = 1'b0;
    lu_req_o     = 1'b0;
    lu_addr_o    = '0;
    upd_valid_o  = 1'b0;
    upd_inval_o  = 1'b0;
    upd_clean_o  = 1'b0;
    upd_shared_o = 1'b0;
    rd_req_o     = 1'b0;
    rd_beat_o    = '0;
    cr_valid_o   = 1'b0;
    cr_resp_o    = '0;
    cd_valid_o   = 1'b0;
    cd_data_o    = '0;
    cd_last_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Ready is withheld while reset is still applied.
        ac_ready_o = ~rst_i;
        if (ac_valid_i) state_d = needs_lookup(ac_snoop_i) ? S_LOOKUP : S_RESP;
      end
      S_LOOKUP: begin
        lu_req_o  = 1'b1;
        lu_addr_o = addr_q;
        if (lu_gnt_i) begin
          state_d = S_RESP;
          if (act.upd) begin
            upd_valid_o  = 1'b1;
            upd_inval_o  = act.inval;
            upd_clean_o  = act.clean;
            upd_shared_o = act.shared;
          end
        end
      end
      S_RESP: begin
        cr_valid_o = 1'b1;
        cr_resp_o  = resp_q;
        if (cr_ready_i) state_d = resp_q.data_transfer ? S_DATA_RD : S_IDLE;
      end
      S_DATA_RD: begin
        rd_req_o  = 1'b1;
        rd_beat_o = beat_q;
        state_d   = S_DATA_TX;
      end
      S_DATA_TX: begin
        cd_valid_o = 1'b1;
        cd_data_o  = data_held_q ? data_q : rd_data_i;
        cd_last_o  = last_beat;
        if (cd_ready_i) state_d = last_beat ? S_IDLE : S_DATA_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, meaning the AC snoop address width.
REQ-002 SHALL have parameter DataWidth, default 64, meaning the CD data beat width.
REQ-003 SHALL have parameter LineBeats, default 4, meaning the CD beats per cache line (power of two, at least 2).
REQ-004 SHALL have clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ac_valid_i / ac_ready_o, in/out, 1 bit each: the AC request handshake.
REQ-007 SHALL have ac_addr_i (in, AddrWidth), ac_snoop_i (in, 4, acsnoop_t) and ac_prot_i (in, 3, acprot_t) as the AC payload.
REQ-008 SHALL have lu_req_o (out, 1) and lu_addr_o (out, AddrWidth) as the cache tag-lookup request.
REQ-009 SHALL have lu_gnt_i, lu_hit_i, lu_dirty_i and lu_shared_i (in, 1 each); the result is valid in the cycle lu_gnt_i is high.
REQ-010 SHALL have upd_valid_o (out, 1), upd_inval_o (out, 1), upd_clean_o (out, 1) and upd_shared_o (out, 1) as a one-cycle line-state update.
REQ-011 SHALL have rd_req_o (out, 1) and rd_beat_o (out, log2 LineBeats) as the line data read port, and rd_data_i (in, DataWidth) valid exactly one cycle after rd_req_o.
REQ-012 SHALL have cr_valid_o / cr_ready_i (out/in, 1) and cr_resp_o (out, 5, resp_t) as the CR channel.
REQ-013 SHALL have cd_valid_o / cd_ready_i (out/in, 1), cd_data_o (out, DataWidth) and cd_last_o (out, 1) as the CD channel.

Function
REQ-014 SHALL implement the FSM IDLE -> LOOKUP -> RESP -> (DATA_RD <-> DATA_TX) -> IDLE, with one snoop outstanding at a time.
REQ-015 SHALL assert ac_ready_o only in IDLE, and SHALL register addr and snoop on the AC handshake, then move to LOOKUP.
REQ-016 SHALL skip LOOKUP for DVM_COMPLETE, DVM_MESSAGE and unlisted encodings, going directly to RESP as a miss.
REQ-017 SHALL, in LOOKUP, hold lu_req_o=1 with lu_addr_o set to the captured address until lu_gnt_i; on grant it SHALL latch hit, dirty and shared and go to RESP.
REQ-018 SHALL, on the LOOKUP-grant cycle, pulse upd_valid_o for one cycle if the snoop type requires a state change and the lookup hit.
REQ-019 SHALL encode cr_resp_o as [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique; WasUnique = hit & ~shared for every looked-up type.
REQ-020 SHALL respond to READ_ONCE: on hit DT=1, IS=1, PD=0, no update.
REQ-021 SHALL respond to READ_SHARED and READ_NOT_SHARED_DIRTY: on hit DT=1, IS=1, PD=dirty, and update shared=1 with clean=dirty.
REQ-022 SHALL respond to READ_CLEAN: on hit DT=1, IS=1, PD=0, and update shared=1.
REQ-023 SHALL respond to READ_UNIQUE: on hit DT=1, PD=dirty, IS=0, and update inval=1.
REQ-024 SHALL respond to CLEAN_SHARED: on hit IS=1 and DT=PD=dirty, and update clean=dirty.
REQ-025 SHALL respond to CLEAN_INVALID: on hit DT=PD=dirty, IS=0, and update inval=1.
REQ-026 SHALL respond to MAKE_INVALID: on hit all bits 0 except WasUnique, and update inval=1.
REQ-027 SHALL give every miss and every DVM type cr_resp_o=5'b00000; unlisted encodings SHALL get 5'b00010.
REQ-028 SHALL, in RESP, hold cr_valid_o and cr_resp_o stable until cr_ready_i; afterwards it SHALL go to DATA_RD if DT=1, else IDLE.
REQ-029 SHALL, in DATA_RD, pulse rd_req_o with rd_beat_o=beat counter, then go to DATA_TX and register rd_data_i into cd_data_o.
REQ-030 SHALL, in DATA_TX, hold cd_valid_o=1 with stable data; cd_last_o=1 iff beat counter = LineBeats-1.
REQ-031 SHALL, on CD handshake, increment the beat counter (wrapping to 0) and go to DATA_RD, or go to IDLE after the last beat; CD never precedes CR.
REQ-032 SHALL ignore ac_prot_i other than capturing it.

Reset
REQ-033 SHALL, while rst_i=1, immediately force state IDLE, beat counter 0, and ac_ready_o=0 with all other outputs 0.
REQ-034 SHALL raise ac_ready_o=1 in the first cycle after deassertion.
REQ-035 SHALL, on reset mid-snoop, abandon the transaction without completing CR or CD.

Verification
REQ-036 SHALL be verified with READ_UNIQUE on hit, dirty=1, shared=0: expect cr_resp_o=5'b10101, one upd pulse with inval=1, and 4 CD beats with last on beat 3.
REQ-037 SHALL be verified with READ_SHARED on miss: expect cr_resp_o=0, no upd pulse, no CD, and return to IDLE.
REQ-038 SHALL be verified with CLEAN_SHARED on hit, clean, shared: expect cr_resp_o=5'b01000 and no CD.
REQ-039 SHALL be verified with DVM_MESSAGE: expect no lu_req_o and cr_resp_o=0; snoop 4'b0100 SHALL get cr_resp_o=5'b00010.
REQ-040 SHALL be verified with cr_ready_i and cd_ready_i held low 5 cycles: expect the payload stable throughout and ac_ready_o=0 until the final handshake.
REQ-041 SHALL be verified with rst_i asserted during beat 2 of READ_ONCE: expect outputs 0 immediately and a fresh snoop accepted after release.
